// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package s2p_pkg;

  // Receive-side state: idle (counter at zero) or holding a partial word.
  typedef enum logic {
    S2P_IDLE  = 1'b0,
    S2P_SHIFT = 1'b1
  } rx_state_e;

  localparam int unsigned S2P_DEFAULT_WIDTH = 4;

  // Bit-counter width able to hold 0..w-1 (at least one bit).
  function automatic int unsigned s2p_cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/s2p_shifter.sv
// Shift register plus bit counter. Raises done_o combinationally in the
// cycle that samples the last bit of a word, with word_o carrying the
// completed word, so the parent can register it on that same edge.
module s2p_shifter
  import s2p_pkg::*;
#(
  parameter int unsigned WIDTH     = S2P_DEFAULT_WIDTH,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] word_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int unsigned CW = s2p_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_in;

  // Bit order: MSB-first shifts left so the first bit ends in the top bit;
  // LSB-first shifts right so the first bit ends in bit 0.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_in = {shift_q[WIDTH-2:0], serial_i};
    end else begin : g_lsb_first
      assign shift_in = {serial_i, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state: shift and count only on valid cycles; wrap on the last bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done_o  = 1'b0;
    if (valid_i) begin
      shift_d = shift_in;
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        done_o  = 1'b1;
        state_d = S2P_IDLE;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = S2P_SHIFT;
      end
    end
  end

  // State, counter and shifter registers; reset drops any partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S2P_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // SHIFT is entered exactly when the counter leaves zero, so it doubles
  // as the partial-word indication.
  assign word_o = shift_in;
  assign busy_o = (state_q == S2P_SHIFT);

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserializer with a valid/ready output register.
// A word completing while the previous one is still unconsumed is dropped
// and flagged on the sticky overrun_o.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int unsigned WIDTH     = S2P_DEFAULT_WIDTH,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_i,
  input  logic             valid_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] parallel_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] word;
  logic             done;
  logic [WIDTH-1:0] par_q, par_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  s2p_shifter #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .serial_i(serial_i),
    .valid_i (valid_i),
    .word_o  (word),
    .done_o  (done),
    .busy_o  (busy_o)
  );

  // Output register: consume on handshake, load on completion if the slot
  // is free or being freed this cycle, otherwise drop and flag overrun.
  // parallel_o is never cleared on consumption.
  always_comb begin
    par_d   = par_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (done) begin
      if (!valid_q || ready_i) begin
        par_d   = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Output and overrun registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      par_q   <= par_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_o = par_q;
  assign valid_o    = valid_q;
  assign overrun_o  = ovr_q;

endmodule
